// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states: normal flow, waiting on a data access, and
    // discarding a wrong-path fetch that is still in flight.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        DISCARD   = 2'd2
    } ctrl_state_e;

    // Hold / bubble request for one pipeline buffer.
    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    // x0 is hard-wired to zero, so it can never carry a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    localparam stage_ctrl_t STAGE_IDLE = '{stall: 1'b0, flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    // Compare both source operands against the EX destination.
    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
        load_use  = ex_mem_read && (ex_rd != REG_X0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Drives PC / IF2ID / ID2EX / EX2MEM / MEM2WB hold and bubble controls and
// keeps saturating performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             if_busy,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic load_use;

    logic        pc_hold;
    stage_ctrl_t if_id_ctrl;
    stage_ctrl_t id_ex_ctrl;
    logic        ex_mem_hold;
    logic        mem_wb_bubble;

    logic load_use_inc;
    logic mem_wait_inc;
    logic redirect_inc;

    logic [CNT_W-1:0] load_use_cnt_q;
    logic [CNT_W-1:0] load_use_cnt_d;
    logic [CNT_W-1:0] mem_wait_cnt_q;
    logic [CNT_W-1:0] mem_wait_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_d;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Priority mux: data-memory wait, then discard squashing, then redirect,
    // then load-use, then instruction-fetch wait; also picks the next state.
    always_comb begin
        state_d       = state_q;
        pc_hold       = 1'b0;
        if_id_ctrl    = STAGE_IDLE;
        id_ex_ctrl    = STAGE_IDLE;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        load_use_inc  = 1'b0;

        if (mem_busy) begin
            // Freeze everything upstream of MEM and bubble WB so the
            // retiring instruction is not written back twice.
            pc_hold          = 1'b1;
            if_id_ctrl.stall = 1'b1;
            id_ex_ctrl.stall = 1'b1;
            ex_mem_hold      = 1'b1;
            mem_wb_bubble    = 1'b1;
            // A pending discard survives the data wait: the wrong-path word
            // still has to be squashed once the pipe moves again.
            if (state_q != DISCARD) begin
                state_d = DMEM_WAIT;
            end
        end else if (state_q == DISCARD) begin
            // Keep the PC on the redirect target and bubble IF2ID until the
            // stale fetch has returned; the return cycle itself is squashed.
            pc_hold          = 1'b1;
            if_id_ctrl.flush = 1'b1;
            if (ex_redirect) begin
                id_ex_ctrl.flush = 1'b1;
            end
            if (!if_busy) begin
                state_d = RUN;
            end
        end else if (ex_redirect) begin
            // PC loads the target; the two younger instructions are wrong-path.
            if_id_ctrl.flush = 1'b1;
            id_ex_ctrl.flush = 1'b1;
            state_d          = if_busy ? DISCARD : RUN;
        end else if (load_use) begin
            pc_hold          = 1'b1;
            if_id_ctrl.stall = 1'b1;
            id_ex_ctrl.flush = 1'b1;
            load_use_inc     = 1'b1;
            state_d          = RUN;
        end else begin
            if (if_busy) begin
                pc_hold          = 1'b1;
                if_id_ctrl.flush = 1'b1;
            end
            state_d = RUN;
        end
    end

    // Event qualifiers for the performance counters.
    always_comb begin
        mem_wait_inc = mem_busy;
        redirect_inc = ex_redirect && !mem_busy;
    end

    // Saturating next-count values: stop at all-ones instead of wrapping.
    always_comb begin
        load_use_cnt_d = load_use_cnt_q;
        mem_wait_cnt_d = mem_wait_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (load_use_inc && (load_use_cnt_q != '1)) begin
            load_use_cnt_d = load_use_cnt_q + CNT_W'(1);
        end
        if (mem_wait_inc && (mem_wait_cnt_q != '1)) begin
            mem_wait_cnt_d = mem_wait_cnt_q + CNT_W'(1);
        end
        if (redirect_inc && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
    end

    // State register; reset drops any pending discard.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Performance counter registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            load_use_cnt_q <= '0;
            mem_wait_cnt_q <= '0;
            redirect_cnt_q <= '0;
        end else begin
            load_use_cnt_q <= load_use_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Controls are combinational, so they are forced low while reset is held.
    always_comb begin
        pc_stall     = ARESETn && pc_hold;
        if_id_stall  = ARESETn && if_id_ctrl.stall;
        if_id_flush  = ARESETn && if_id_ctrl.flush;
        id_ex_stall  = ARESETn && id_ex_ctrl.stall;
        id_ex_flush  = ARESETn && id_ex_ctrl.flush;
        ex_mem_stall = ARESETn && ex_mem_hold;
        mem_wb_flush = ARESETn && mem_wb_bubble;
    end

    assign load_use_cnt = load_use_cnt_q;
    assign mem_wait_cnt = mem_wait_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: combinational vector table plus multi-cycle
// sequences for data waits, discard, saturation and reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned CW = 4;

    // Control vector order: pc, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_flush.
    localparam logic [6:0] C_IDLE = 7'b000_0000;
    localparam logic [6:0] C_MEM  = 7'b110_1011;
    localparam logic [6:0] C_RDR  = 7'b001_0100;
    localparam logic [6:0] C_LU   = 7'b110_0100;
    localparam logic [6:0] C_IFB  = 7'b101_0000;
    localparam logic [6:0] C_DRDR = 7'b101_0100;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic          ex_redirect = 1'b0, if_busy = 1'b0, mem_busy = 1'b0;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_stall, mem_wb_flush;
    logic [CW-1:0] load_use_cnt, mem_wait_cnt, redirect_cnt;
    logic [6:0]    ctrl;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_flush (mem_wb_flush),
        .load_use_cnt (load_use_cnt),
        .mem_wait_cnt (mem_wait_cnt),
        .redirect_cnt (redirect_cnt)
    );

    always #5 ACLK = ~ACLK;

    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, mem_wb_flush};

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       rdr;
        logic       ifb;
        logic       memb;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic rdr, input logic ifb,
                          input logic memb);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_redirect = rdr;
        if_busy = ifb; mem_busy = memb;
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive at the falling edge, let the combinational outputs settle, check.
    task automatic step(input string name, input logic [6:0] exp);
        #1;
        chk(name, {25'd0, ctrl}, {25'd0, exp});
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        idle_in();
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
    endtask

    initial begin
        vecs[0]  = '{"idle",       5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
        vecs[1]  = '{"lu_rs2",     5'd0,  5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[2]  = '{"lu_x0",      5'd0,  5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE};
        vecs[3]  = '{"lu_rs1",     5'd7,  5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[4]  = '{"rs1_unused", 5'd7,  5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE};
        vecs[5]  = '{"not_load",   5'd7,  5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
        vecs[6]  = '{"redirect",   5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_RDR};
        vecs[7]  = '{"if_busy",    5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_IFB};
        vecs[8]  = '{"lu_over_if", 5'd0,  5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, C_LU};
        vecs[9]  = '{"rdr_over_lu",5'd0,  5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, C_RDR};
        vecs[10] = '{"mem_busy",   5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM};
        vecs[11] = '{"mem_over_all",5'd0, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, C_MEM};
        vecs[12] = '{"lu_both",    5'd31, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};

        // Reset: controls and counters are zero even with active inputs.
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        #12;
        chk("reset_ctrl", {25'd0, ctrl}, 32'd0);
        chk("reset_cnt", {20'd0, load_use_cnt, mem_wait_cnt, redirect_cnt}, 32'd0);
        do_reset();

        // Combinational priority table.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
                   vecs[i].mr, vecs[i].rdr, vecs[i].ifb, vecs[i].memb);
            step(vecs[i].name, vecs[i].exp);
        end
        do_reset();

        // Single load-use cycle, then the same with ex_rd = x0.
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("seq_lu", C_LU);
        idle_in();
        step("seq_lu_done", C_IDLE);
        chk("lu_cnt_1", {28'd0, load_use_cnt}, 32'd1);
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("seq_lu_x0", C_IDLE);
        chk("lu_cnt_x0", {28'd0, load_use_cnt}, 32'd1);

        // Three data-wait cycles.
        idle_in(); mem_busy = 1'b1;
        step("mem_c1", C_MEM);
        chk("state_dmem", {30'd0, dut.state_q}, {30'd0, DMEM_WAIT});
        step("mem_c2", C_MEM);
        step("mem_c3", C_MEM);
        idle_in();
        step("mem_done", C_IDLE);
        chk("mem_cnt_3", {28'd0, mem_wait_cnt}, 32'd3);
        chk("state_run1", {30'd0, dut.state_q}, {30'd0, RUN});

        // Redirect with no fetch outstanding.
        ex_redirect = 1'b1;
        step("rdr_plain", C_RDR);
        idle_in();
        step("rdr_plain_done", C_IDLE);
        chk("rdr_cnt_1", {28'd0, redirect_cnt}, 32'd1);

        // Redirect with a fetch in flight: discard until it returns.
        ex_redirect = 1'b1; if_busy = 1'b1;
        step("disc_enter", C_RDR);
        chk("state_disc", {30'd0, dut.state_q}, {30'd0, DISCARD});
        ex_redirect = 1'b0;
        step("disc_wait", C_IFB);
        ex_redirect = 1'b1;
        step("disc_rdr", C_DRDR);
        chk("rdr_cnt_3", {28'd0, redirect_cnt}, 32'd3);
        chk("state_disc2", {30'd0, dut.state_q}, {30'd0, DISCARD});
        ex_redirect = 1'b0; mem_busy = 1'b1;
        step("disc_mem", C_MEM);
        chk("state_disc3", {30'd0, dut.state_q}, {30'd0, DISCARD});
        mem_busy = 1'b0; if_busy = 1'b0;
        step("disc_squash", C_IFB);
        chk("state_run2", {30'd0, dut.state_q}, {30'd0, RUN});
        step("disc_done", C_IDLE);

        // Data wait overrides redirect and load-use; counters reflect that.
        set_in(5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        step("mem_override", C_MEM);
        idle_in();
        chk("rdr_cnt_hold", {28'd0, redirect_cnt}, 32'd3);
        chk("lu_cnt_hold", {28'd0, load_use_cnt}, 32'd1);
        chk("mem_cnt_5", {28'd0, mem_wait_cnt}, 32'd5);

        // Saturation: 5 + 9 = 14, then three more cycles stop at 15.
        mem_busy = 1'b1;
        repeat (9) @(negedge ACLK);
        chk("mem_cnt_14", {28'd0, mem_wait_cnt}, 32'd14);
        repeat (3) @(negedge ACLK);
        chk("mem_cnt_sat", {28'd0, mem_wait_cnt}, 32'd15);
        mem_busy = 1'b0;
        @(negedge ACLK);

        // Reset while discarding.
        ex_redirect = 1'b1; if_busy = 1'b1;
        @(negedge ACLK);
        ex_redirect = 1'b0;
        chk("state_disc4", {30'd0, dut.state_q}, {30'd0, DISCARD});
        ARESETn = 1'b0;
        #1;
        chk("rst_mid_ctrl", {25'd0, ctrl}, 32'd0);
        chk("rst_mid_cnt", {20'd0, load_use_cnt, mem_wait_cnt, redirect_cnt}, 32'd0);
        chk("rst_mid_state", {30'd0, dut.state_q}, {30'd0, RUN});
        @(negedge ACLK);
        ARESETn = 1'b1;
        if_busy = 1'b0;
        step("post_rst_idle", C_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
